// File: rtl/stereo_pixel_fifo_pkg.sv
// Shared defaults and elaboration helpers for the pixel FIFO family
// (line-buffer, DDR-writer and stereo channel FIFOs).
package stereo_pixel_fifo_pkg;

    localparam int PIX_W_DEF   = 24;
    localparam int LINE_AW_DEF = 9;

    // Thresholds must leave a non-empty band between almost_empty and almost_full.
    function automatic bit thresh_ok(int aempty, int afull, int aw);
        return (aempty >= 0) && (aempty < afull) && (afull <= (1 << aw));
    endfunction

endpackage

// File: rtl/stereo_pixel_fifo_if.sv
// Write/read handshake and status bundle of one camera-channel pixel FIFO.
interface stereo_pixel_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 9
);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/stereo_pixel_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, block-RAM inferable.
module stereo_pixel_fifo_sdp_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/stereo_pixel_fifo.sv
// Synchronous pixel FIFO with occupancy, programmable thresholds, flush and sticky errors.
module stereo_pixel_fifo
    import stereo_pixel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = PIX_W_DEF,
    parameter int ADDR_WIDTH    = LINE_AW_DEF,
    parameter int AFULL_THRESH  = 480,
    parameter int AEMPTY_THRESH = 32
) (
    input  logic                clk,
    input  logic                reset,
    stereo_pixel_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

`ifndef SYNTHESIS
    if (!thresh_ok(AEMPTY_THRESH, AFULL_THRESH, ADDR_WIDTH)) begin : g_bad_thresh
        $error("stereo_pixel_fifo: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
`endif

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_acc, rd_acc;

    assign wr_acc = bus.wr_en & ~full_q  & ~bus.clear;
    assign rd_acc = bus.rd_en & ~empty_q & ~bus.clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_acc);
        level_d    = level_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
        ovf_d      = ovf_q | (bus.wr_en & full_q);
        unf_d      = unf_q | (bus.rd_en & empty_q);
        rd_valid_d = rd_acc;
        // The RAM output register has no reset; hold_q keeps the last delivered word instead.
        hold_d     = rd_valid_q ? ram_rdata : hold_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            rd_valid_d = 1'b0;
        end
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_valid_q <= rd_valid_d;
            hold_q     <= hold_d;
        end
    end

    stereo_pixel_fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign bus.rd_data      = rd_valid_q ? ram_rdata : hold_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
